// File: rtl/bst_engine.sv
// Binary-search-tree key store with insert/find/remove/clear over a valid/ready handshake.
// One tree node is visited per WALK cycle. Removed keys stay in the tree as tombstones until a clear.
module bst_engine #(
    parameter int KEY_W = 4,
    parameter int NODES = 8,
    localparam int PTR_W = $clog2(NODES),
    localparam int CNT_W = $clog2(NODES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [KEY_W-1:0] key,
    output logic             op_ready,
    output logic             res_valid,
    output logic             res_hit,
    output logic             res_err,
    output logic [PTR_W-1:0] res_depth,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_REMOVE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [KEY_W-1:0]   opkey_q, opkey_d;
    logic [PTR_W-1:0]   cur_q, cur_d;
    logic [PTR_W-1:0]   depth_q, depth_d;
    logic               dir_right_q, dir_right_d;
    logic               root_valid_q, root_valid_d;
    logic [CNT_W-1:0]   alloc_q, alloc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               res_hit_q, res_hit_d;
    logic               res_err_q, res_err_d;
    logic [PTR_W-1:0]   res_depth_q, res_depth_d;

    logic [KEY_W-1:0]   node_key_q   [NODES];
    logic [KEY_W-1:0]   node_key_d   [NODES];
    logic [PTR_W-1:0]   node_left_q  [NODES];
    logic [PTR_W-1:0]   node_left_d  [NODES];
    logic [PTR_W-1:0]   node_right_q [NODES];
    logic [PTR_W-1:0]   node_right_d [NODES];
    logic               node_lv_q    [NODES];
    logic               node_lv_d    [NODES];
    logic               node_rv_q    [NODES];
    logic               node_rv_d    [NODES];
    logic               node_live_q  [NODES];
    logic               node_live_d  [NODES];

    logic               alloc_we;
    logic               link_we;
    logic               live_we;
    logic               live_val;

    logic [KEY_W-1:0]   cur_key;
    logic               cur_live;
    logic               key_match;
    logic               go_left;
    logic               child_ok;
    logic [PTR_W-1:0]   child_ptr;
    logic [PTR_W-1:0]   alloc_idx;
    logic               full_w;

    // Root always lives in entry 0 because allocation restarts at 0 after reset/clear.
    assign cur_key   = node_key_q[cur_q];
    assign cur_live  = node_live_q[cur_q];
    assign key_match = root_valid_q && (opkey_q == cur_key);
    assign go_left   = opkey_q < cur_key;
    assign child_ok  = go_left ? node_lv_q[cur_q] : node_rv_q[cur_q];
    assign child_ptr = go_left ? node_left_q[cur_q] : node_right_q[cur_q];
    assign alloc_idx = alloc_q[PTR_W-1:0];
    assign full_w    = (alloc_q == CNT_W'(NODES));

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        opkey_d      = opkey_q;
        cur_d        = cur_q;
        depth_d      = depth_q;
        dir_right_d  = dir_right_q;
        root_valid_d = root_valid_q;
        alloc_d      = alloc_q;
        count_d      = count_q;
        res_hit_d    = res_hit_q;
        res_err_d    = res_err_q;
        res_depth_d  = res_depth_q;
        alloc_we     = 1'b0;
        link_we      = 1'b0;
        live_we      = 1'b0;
        live_val     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_d    = op;
                    opkey_d = key;
                    cur_d   = '0;
                    depth_d = '0;
                    // Clear spends one cycle in WRITE so every storage update lands on the DONE-entry edge.
                    state_d = (op == OP_CLEAR) ? S_WRITE : S_WALK;
                end
            end
            S_WALK: begin
                if (key_match) begin
                    state_d   = S_DONE;
                    res_err_d = 1'b0;
                    case (op_q)
                        OP_INSERT: begin
                            res_depth_d = depth_q;
                            res_hit_d   = cur_live;
                            if (!cur_live) begin
                                live_we  = 1'b1;
                                live_val = 1'b1;
                                count_d  = count_q + CNT_W'(1);
                            end
                        end
                        OP_REMOVE: begin
                            res_hit_d   = cur_live;
                            res_depth_d = cur_live ? depth_q : '0;
                            if (cur_live) begin
                                live_we  = 1'b1;
                                live_val = 1'b0;
                                count_d  = count_q - CNT_W'(1);
                            end
                        end
                        default: begin
                            res_hit_d   = cur_live;
                            res_depth_d = cur_live ? depth_q : '0;
                        end
                    endcase
                end else if (root_valid_q && child_ok) begin
                    cur_d   = child_ptr;
                    depth_d = depth_q + PTR_W'(1);
                end else if (op_q == OP_INSERT && !full_w) begin
                    state_d     = S_WRITE;
                    dir_right_d = !go_left;
                    depth_d     = root_valid_q ? depth_q + PTR_W'(1) : '0;
                end else begin
                    state_d     = S_DONE;
                    res_hit_d   = 1'b0;
                    res_err_d   = (op_q == OP_INSERT);
                    res_depth_d = '0;
                end
            end
            S_WRITE: begin
                state_d   = S_DONE;
                res_hit_d = 1'b0;
                res_err_d = 1'b0;
                if (op_q == OP_CLEAR) begin
                    root_valid_d = 1'b0;
                    alloc_d      = '0;
                    count_d      = '0;
                    res_depth_d  = '0;
                end else begin
                    alloc_we     = 1'b1;
                    link_we      = root_valid_q;
                    root_valid_d = 1'b1;
                    alloc_d      = alloc_q + CNT_W'(1);
                    count_d      = count_q + CNT_W'(1);
                    res_depth_d  = depth_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        node_key_d   = node_key_q;
        node_left_d  = node_left_q;
        node_right_d = node_right_q;
        node_lv_d    = node_lv_q;
        node_rv_d    = node_rv_q;
        node_live_d  = node_live_q;
        if (alloc_we) begin
            node_key_d[alloc_idx]  = opkey_q;
            node_lv_d[alloc_idx]   = 1'b0;
            node_rv_d[alloc_idx]   = 1'b0;
            node_live_d[alloc_idx] = 1'b1;
        end
        // The parent (cur_q) is always an older entry than alloc_idx, so these never collide.
        if (link_we) begin
            if (dir_right_q) begin
                node_right_d[cur_q] = alloc_idx;
                node_rv_d[cur_q]    = 1'b1;
            end else begin
                node_left_d[cur_q] = alloc_idx;
                node_lv_d[cur_q]   = 1'b1;
            end
        end
        if (live_we) begin
            node_live_d[cur_q] = live_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            opkey_q      <= '0;
            cur_q        <= '0;
            depth_q      <= '0;
            dir_right_q  <= 1'b0;
            root_valid_q <= 1'b0;
            alloc_q      <= '0;
            count_q      <= '0;
            res_hit_q    <= 1'b0;
            res_err_q    <= 1'b0;
            res_depth_q  <= '0;
            for (int i = 0; i < NODES; i++) begin
                node_key_q[i]   <= '0;
                node_left_q[i]  <= '0;
                node_right_q[i] <= '0;
                node_lv_q[i]    <= 1'b0;
                node_rv_q[i]    <= 1'b0;
                node_live_q[i]  <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            opkey_q      <= opkey_d;
            cur_q        <= cur_d;
            depth_q      <= depth_d;
            dir_right_q  <= dir_right_d;
            root_valid_q <= root_valid_d;
            alloc_q      <= alloc_d;
            count_q      <= count_d;
            res_hit_q    <= res_hit_d;
            res_err_q    <= res_err_d;
            res_depth_q  <= res_depth_d;
            node_key_q   <= node_key_d;
            node_left_q  <= node_left_d;
            node_right_q <= node_right_d;
            node_lv_q    <= node_lv_d;
            node_rv_q    <= node_rv_d;
            node_live_q  <= node_live_d;
        end
    end

    assign op_ready  = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign res_hit   = res_hit_q;
    assign res_err   = res_err_q;
    assign res_depth = res_depth_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = full_w;

endmodule

// File: tb/tb_bst_engine.sv
// Bench for bst_engine: a vector table drives ops, a scoreboard checks each result strobe,
// then hand-written sequences cover busy-time op_valid, mid-walk reset and recovery.
module tb_bst_engine;

    localparam int KEY_W = 4;
    localparam int NODES = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;

    localparam logic [1:0] OP_INS = 2'b00;
    localparam logic [1:0] OP_FND = 2'b01;
    localparam logic [1:0] OP_REM = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             op_valid = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [KEY_W-1:0] key = '0;
    logic             op_ready;
    logic             res_valid;
    logic             res_hit;
    logic             res_err;
    logic [PTR_W-1:0] res_depth;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;

    bst_engine #(.KEY_W(KEY_W), .NODES(NODES)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op        (op),
        .key       (key),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_hit   (res_hit),
        .res_err   (res_err),
        .res_depth (res_depth),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int tag = 0;

    typedef struct {
        logic             hit;
        logic             err;
        logic [PTR_W-1:0] depth;
        logic [CNT_W-1:0] cnt;
        logic             fl;
        int               due;
        int               tag;
    } exp_t;

    typedef struct {
        logic [1:0]       op;
        logic [KEY_W-1:0] key;
        logic             hit;
        logic             err;
        logic [PTR_W-1:0] depth;
        logic [CNT_W-1:0] cnt;
        logic             fl;
        int               lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[40];
    int   nvec = 0;

    task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s op#%0d actual=%0d required=%0d", name, t, act, req);
        end
    endtask

    task automatic add_vec(input logic [1:0] o, input int k, input logic h, input logic e,
                           input int d, input int c, input logic f, input int lat);
        vec_t v;
        v.op = o; v.key = KEY_W'(k); v.hit = h; v.err = e;
        v.depth = PTR_W'(d); v.cnt = CNT_W'(c); v.fl = f; v.lat = lat;
        vecs[nvec] = v;
        nvec++;
    endtask

    // Called at a falling edge with the engine idle; returns at the falling edge after the result.
    task automatic do_op(input logic [1:0] o, input int k, input logic h, input logic e,
                         input int d, input int c, input logic f, input int lat, input bit hold);
        exp_t ex;
        bit   got;
        int   waited;
        check("op_ready_idle", tag, 32'(op_ready), 1);
        op_valid = 1'b1;
        op  = o;
        key = KEY_W'(k);
        ex.hit = h; ex.err = e; ex.depth = PTR_W'(d); ex.cnt = CNT_W'(c); ex.fl = f;
        ex.due = cyc + lat; ex.tag = tag;
        sb.push_back(ex);
        @(negedge clk);
        if (!hold) op_valid = 1'b0;
        check("op_ready_busy", tag, 32'(op_ready), 0);
        got = 0;
        waited = 0;
        while (!got && waited < 40) begin
            if (res_valid === 1'b1) got = 1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL res_valid_timeout op#%0d actual=none required=strobe", tag);
        end
        op_valid = 1'b0;
        @(negedge clk);
        tag++;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res_valid cycle=%0d actual=1 required=0", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("res_hit",   mon_e.tag, 32'(res_hit),   32'(mon_e.hit));
                check("res_err",   mon_e.tag, 32'(res_err),   32'(mon_e.err));
                check("res_depth", mon_e.tag, 32'(res_depth), 32'(mon_e.depth));
                check("count",     mon_e.tag, 32'(count),     32'(mon_e.cnt));
                check("empty",     mon_e.tag, 32'(empty),     32'(mon_e.cnt == 0));
                check("full",      mon_e.tag, 32'(full),      32'(mon_e.fl));
                check("latency",   mon_e.tag, 32'(cyc),       32'(mon_e.due));
            end
        end
    end

    task automatic check_reset_outputs(input string where);
        check({where, "_op_ready"},  tag, 32'(op_ready),  1);
        check({where, "_res_valid"}, tag, 32'(res_valid), 0);
        check({where, "_res_hit"},   tag, 32'(res_hit),   0);
        check({where, "_res_err"},   tag, 32'(res_err),   0);
        check({where, "_res_depth"}, tag, 32'(res_depth), 0);
        check({where, "_count"},     tag, 32'(count),     0);
        check({where, "_empty"},     tag, 32'(empty),     1);
        check({where, "_full"},      tag, 32'(full),      0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // op, key, hit, err, depth, count, full, latency
        add_vec(OP_INS, 1,  0, 0, 0, 1, 0, 3);
        add_vec(OP_INS, 10, 0, 0, 1, 2, 0, 3);
        add_vec(OP_INS, 8,  0, 0, 2, 3, 0, 4);
        add_vec(OP_FND, 8,  1, 0, 2, 3, 0, 4);
        add_vec(OP_FND, 3,  0, 0, 0, 3, 0, 4);
        add_vec(OP_INS, 10, 1, 0, 1, 3, 0, 3);
        add_vec(OP_REM, 10, 1, 0, 1, 2, 0, 3);
        add_vec(OP_FND, 10, 0, 0, 0, 2, 0, 3);
        add_vec(OP_FND, 8,  1, 0, 2, 2, 0, 4);
        add_vec(OP_INS, 10, 0, 0, 1, 3, 0, 3);
        add_vec(OP_CLR, 0,  0, 0, 0, 0, 0, 2);
        add_vec(OP_INS, 0,  0, 0, 0, 1, 0, 3);
        for (int k = 1; k < 8; k++) add_vec(OP_INS, k, 0, 0, k, k + 1, (k == 7), k + 2);
        add_vec(OP_INS, 9,  0, 1, 0, 8, 1, 9);
        add_vec(OP_INS, 5,  1, 0, 5, 8, 1, 7);
        add_vec(OP_FND, 7,  1, 0, 7, 8, 1, 9);
        add_vec(OP_REM, 0,  1, 0, 0, 7, 1, 2);
        add_vec(OP_INS, 0,  0, 0, 0, 8, 1, 2);
        add_vec(OP_CLR, 0,  0, 0, 0, 0, 0, 2);

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < nvec; i++) begin
            do_op(vecs[i].op, int'(vecs[i].key), vecs[i].hit, vecs[i].err,
                  int'(vecs[i].depth), int'(vecs[i].cnt), vecs[i].fl, vecs[i].lat, 1'b0);
        end

        // Clear with op_valid held through the busy period: exactly one op taken.
        do_op(OP_INS, 1,  0, 0, 0, 1, 0, 3, 1'b0);
        do_op(OP_INS, 10, 0, 0, 1, 2, 0, 3, 1'b0);
        do_op(OP_INS, 8,  0, 0, 2, 3, 0, 4, 1'b0);
        do_op(OP_CLR, 0,  0, 0, 0, 0, 0, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("post_clear_idle", tag, 32'(op_ready), 1);
            @(negedge clk);
        end

        // Reset in the middle of a walk.
        do_op(OP_INS, 1,  0, 0, 0, 1, 0, 3, 1'b0);
        do_op(OP_INS, 10, 0, 0, 1, 2, 0, 3, 1'b0);
        do_op(OP_INS, 8,  0, 0, 2, 3, 0, 4, 1'b0);
        do_op(OP_FND, 8,  1, 0, 2, 3, 0, 4, 1'b0);
        op_valid = 1'b1;
        op  = OP_FND;
        key = KEY_W'(8);
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midwalk");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_res_valid", tag, 32'(res_valid), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        do_op(OP_FND, 8, 0, 0, 0, 0, 0, 2, 1'b0);
        do_op(OP_INS, 8, 0, 0, 0, 1, 0, 3, 1'b0);
        do_op(OP_FND, 1, 0, 0, 0, 1, 0, 2, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drain", tag, 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
